// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DMEM_DWIDTH     = 16;
  localparam int unsigned DMEM_ADDR_WIDTH = 16;
  localparam int unsigned DMEM_CWIDTH     = 16;
  localparam int unsigned STATE_W         = 3;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    WR_ISSUE   = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RESP       = 3'd4,
    DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store bridge between the core and a byte-wide data RAM,
// with a sticky halt that parks the controller in a terminal dump state.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DWIDTH     = DMEM_DWIDTH,
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned CWIDTH     = DMEM_CWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DWIDTH-1:0]     rsp_rdata,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]     ram_din,
  output logic                  ram_we,
  input  logic [DWIDTH-1:0]     ram_dout,
  output logic                  ram_done,
  output logic [CWIDTH-1:0]     rd_count,
  output logic [CWIDTH-1:0]     wr_count
);

  state_e                state_q, state_d;
  logic                  halt_pend_q, halt_pend_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DWIDTH-1:0]     ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_done_q, ram_done_d;
  logic                  wr_inc, rd_inc;
  logic                  unused_dout_hi;

  // The RAM is byte wide; the upper dout bits carry nothing meaningful.
  assign unused_dout_hi = ^ram_dout[DWIDTH-1:BYTE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      halt_pend_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      ram_done_q  <= ram_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q | halt;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    ram_done_d  = ram_done_q;
    wr_inc      = 1'b0;
    rd_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        // A request seen together with a fresh halt is still taken; halt retires after it.
        if (halt_pend_q) begin
          state_d = DONE;
        end else if (req_valid && req_ready_q) begin
          ram_addr_d = req_addr;
          ram_din_d  = req_wdata;
          ram_we_d   = req_we;
          state_d    = req_we ? WR_ISSUE : RD_ISSUE;
        end else if (halt) begin
          state_d = DONE;
        end
      end
      WR_ISSUE: begin
        wr_inc  = 1'b1;
        state_d = halt_pend_d ? DONE : IDLE;
      end
      RD_ISSUE: begin
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        rsp_rdata_d = DWIDTH'(ram_dout[BYTE_W-1:0]);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rd_inc      = 1'b1;
          state_d     = halt_pend_d ? DONE : IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      ram_done_d  = 1'b1;
      rsp_valid_d = 1'b0;
    end
    req_ready_d = (state_d == IDLE);
  end

  sat_counter #(.W(CWIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_inc),
    .q     (wr_count)
  );

  sat_counter #(.W(CWIDTH)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_inc),
    .q     (rd_count)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign ram_done  = ram_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized checks of data_mem_ctrl against a byte-RAM model
// and a transaction-level reference (memory image and saturating counts).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready, halt;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, ram_we, ram_done;
  logic [15:0] rsp_rdata, ram_addr, ram_din, ram_dout, rd_count, wr_count;

  data_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .halt      (halt),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .ram_done  (ram_done),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM with registered read; output floats while writing, junk in upper byte.
  logic [7:0]  ram_mem [256];
  logic [15:0] ram_dout_r = 'x;
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_din[7:0];
      ram_dout_r             <= 'z;
    end else begin
      ram_dout_r <= {8'h5A, ram_mem[ram_addr[7:0]]};
    end
  end
  assign ram_dout = ram_dout_r;

  logic [7:0] ref_mem [256];
  int         exp_wr, exp_rd;
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic int sat_inc(input int v);
    return (v >= 'hFFFF) ? 'hFFFF : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_done", 32'(ram_done), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    check("rst_wr_count", 32'(wr_count), 0);
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    check("st_req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    check("st_we_high", 32'(ram_we), 1);
    check("st_ram_addr", 32'(ram_addr), 32'(a));
    check("st_ram_din", 32'(ram_din), 32'(d));
    check("st_req_ready_busy", 32'(req_ready), 0);
    ref_mem[a[7:0]] = d[7:0];
    exp_wr = sat_inc(exp_wr);
    tick();
    check("st_we_low", 32'(ram_we), 0);
    check("st_wr_count", 32'(wr_count), 32'(exp_wr));
    check("st_req_ready_back", 32'(req_ready), 1);
  endtask

  // Handshake edge is cycle 1; rsp_valid must first appear after the third edge.
  task automatic do_load(input logic [15:0] a, input int delay, input bit with_halt);
    logic [15:0] exp_data;
    check("ld_req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'($urandom);
    halt = with_halt; rsp_ready = (delay == 0);
    exp_data = {8'h00, ref_mem[a[7:0]]};
    tick();
    req_valid = 1'b0; halt = 1'b0;
    check("ld_we_low", 32'(ram_we), 0);
    check("ld_ram_addr", 32'(ram_addr), 32'(a));
    check("ld_valid_c1", 32'(rsp_valid), 0);
    check("ld_req_ready_busy", 32'(req_ready), 0);
    tick();
    check("ld_valid_c2", 32'(rsp_valid), 0);
    tick();
    check("ld_valid_c3", 32'(rsp_valid), 1);
    check("ld_rdata", 32'(rsp_rdata), 32'(exp_data));
    for (int i = 1; i < delay; i++) begin
      tick();
      check("ld_hold_valid", 32'(rsp_valid), 1);
      check("ld_hold_rdata", 32'(rsp_rdata), 32'(exp_data));
      check("ld_hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_rd = sat_inc(exp_rd);
    check("ld_valid_clear", 32'(rsp_valid), 0);
    check("ld_rd_count", 32'(rd_count), 32'(exp_rd));
    check("ld_req_ready_after", 32'(req_ready), with_halt ? 0 : 1);
    check("ld_ram_done", 32'(ram_done), with_halt ? 1 : 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; halt = 1'b0;
    exp_wr = 0; exp_rd = 0;

    repeat (2) tick();
    check_reset_outs();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", 32'(req_ready), 1);

    // Directed store, immediate-consume load, stalled load.
    do_store(16'h0010, 16'h00AB);
    do_load(16'h0010, 0, 1'b0);
    do_load(16'h0010, 5, 1'b0);

    // Reset while the load is in RD_ISSUE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    exp_wr = 0; exp_rd = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst2_req_ready", 32'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst2_no_rsp", 32'(rsp_valid), 0);
    end

    // Random mix of stores and loads.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_store(16'($urandom_range(0, 255)), 16'($urandom));
      else
        do_load(16'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);
    end

    // Saturation of the store counter.
    force dut.u_wr_cnt.cnt_q = 16'hFFFE;
    #1;
    release dut.u_wr_cnt.cnt_q;
    exp_wr = 'hFFFE;
    check("sat_preset", 32'(wr_count), 32'(exp_wr));
    do_store(16'h0031, 16'h1234);
    do_store(16'h0032, 16'h5678);

    // Halt together with a load: load retires, then terminal dump state.
    do_load(16'h0031, 0, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_wdata = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("done_ram_done", 32'(ram_done), 1);
      check("done_req_ready", 32'(req_ready), 0);
      check("done_ram_we", 32'(ram_we), 0);
      check("done_rsp_valid", 32'(rsp_valid), 0);
      check("done_wr_count", 32'(wr_count), 32'(exp_wr));
    end
    req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, meaning the core-side data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the data memory address width.
REQ-003 The block SHALL have parameter CWIDTH, default 16, meaning the access-counter width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; both ports are listed first below.
REQ-005 The ports SHALL be, in order:
- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core memory request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DWIDTH  store data.
- req_ready  out  1  request accepted when high with req_valid.
- rsp_valid  out  1  load data valid.
- rsp_ready  in  1  core consumes rsp.
- rsp_rdata  out  DWIDTH  load data, zero-extended byte.
- halt  in  1  core finished; begin memory dump.
- ram_addr  out  ADDR_WIDTH  to data RAM addr.
- ram_din  out  DWIDTH  to data RAM din.
- ram_we  out  1  to data RAM we.
- ram_dout  in  DWIDTH  from data RAM dout; registered read, high-Z during write.
- ram_done  out  1  to data RAM done; starts dump.
- rd_count  out  CWIDTH  loads completed.
- wr_count  out  CWIDTH  stores issued.

Function
REQ-006 FSM states SHALL be IDLE, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RESP, DONE.
REQ-007 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-008 A handshake (req_valid & req_ready) SHALL register ram_addr <= req_addr and ram_din <= req_wdata at that edge.
REQ-009 A handshake with req_we=1 SHALL set ram_we=1 and go to WR_ISSUE.
REQ-010 WR_ISSUE SHALL last exactly one cycle, clear ram_we, increment wr_count, and return to IDLE.
REQ-011 A handshake with req_we=0 SHALL keep ram_we=0 and go to RD_ISSUE.
REQ-012 RD_ISSUE SHALL advance to RD_CAPTURE after one cycle, while the RAM registers dout.
REQ-013 RD_CAPTURE SHALL register rsp_rdata <= {zeros, ram_dout[7:0]}, set rsp_valid=1, and go to RESP.
REQ-014 The load latency from handshake edge to rsp_valid high SHALL be 3 cycles.
REQ-015 ram_dout SHALL be sampled only in RD_CAPTURE; its Z/X value in any other state SHALL never propagate.
REQ-016 RESP SHALL hold rsp_valid and rsp_rdata stable until rsp_ready=1.
REQ-017 On that rsp_ready edge, RESP SHALL clear rsp_valid, increment rd_count, and return to IDLE.
REQ-018 When rsp_ready is already high on entry to RESP, the response SHALL complete in one cycle.
REQ-019 Only one request SHALL be outstanding at any time.
REQ-020 Stores SHALL write only req_wdata[7:0] to the byte-wide RAM; upper bits are driven but ignored.
REQ-021 halt=1 on any edge SHALL set a sticky halt_pend flag.
REQ-022 In IDLE with halt_pend=1, the FSM SHALL enter DONE instead of accepting a request.
REQ-023 halt and req_valid in the same IDLE cycle SHALL accept the request first; DONE is entered after it retires.
REQ-024 DONE SHALL be terminal until reset: ram_done=1, ram_we=0, req_ready=0, rsp_valid=0.
REQ-025 rd_count and wr_count SHALL saturate at all-ones and never wrap.
REQ-026 Address arithmetic SHALL be pass-through with no increment, so address wrap-around is not applicable.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE and halt_pend=0.
REQ-028 While rst_n=0, every output except req_ready SHALL be 0, including ram_addr, ram_din, ram_we, ram_done, rsp_valid, rsp_rdata and both counters.
REQ-029 req_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-030 Reset mid-transaction SHALL abort it, drop ram_we immediately, and discard any pending response.

Structure
REQ-031 The state enum, state widths and default parameter values SHALL live in shared package dmem_pkg.
REQ-032 The saturating counter SHALL be a sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output q), instanced twice.

Verification
REQ-033 Store 0x00AB to 0x0010 -> ram_we high exactly 1 cycle with ram_addr=0x0010 and ram_din=0x00AB; wr_count=1.
REQ-034 Load 0x0010 after REQ-033, rsp_ready=1 -> rsp_valid exactly 3 cycles after handshake with rsp_rdata=0x00AB; rd_count=1.
REQ-035 Load with rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable 5 cycles, req_ready=0 throughout.
REQ-036 halt with req_valid (load) in the same cycle -> load completes, then DONE: ram_done=1, req_ready=0 permanently.
REQ-037 rst_n low during RD_ISSUE -> immediate IDLE, no rsp_valid after release, counters=0.
REQ-038 Force wr_count to 0xFFFF, then issue a store -> wr_count stays 0xFFFF.
